// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants and the redirect FSM state type.
package riscv_pkg;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HOLD     = 2'd2
  } redir_state_e;
endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/branch_redirect_unit.sv
// EX-stage control-transfer resolution: registered PC redirect, flushes
// and branch performance counters for a predict-not-taken front end.
module branch_redirect_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic             ex_decision,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             if_stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             target_misalig,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             squash_ex,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);
  redir_state_e    r_state;
  redir_state_e    w_next;
  logic [XLEN-1:0] r_target;

  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_accept;
  logic            w_taken;
  logic            w_br_inc;
  logic            w_tk_inc;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic            w_active;

  assign w_is_br   = (ex_opcode == OP_BRANCH);
  assign w_is_jal  = (ex_opcode == OP_JAL);
  assign w_is_jalr = (ex_opcode == OP_JALR);

  // EX inputs outside IDLE belong to the wrong path
  assign w_accept = (r_state == ST_IDLE) && ex_valid;
  assign w_taken  = w_accept &&
                    ((w_is_br && ex_decision) || w_is_jal || w_is_jalr);

  assign w_base   = w_is_jalr ? ex_rs1 : ex_pc;
  assign w_sum    = w_base + ex_imm;
  assign w_target = w_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

  assign w_br_inc = w_accept && w_is_br;
  assign w_tk_inc = w_br_inc && ex_decision;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_taken) begin
        r_target <= w_target;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_taken) w_next = ST_REDIRECT;
      end
      ST_REDIRECT,
      ST_HOLD: begin
        w_next = if_stall ? ST_HOLD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_active       = (r_state != ST_IDLE);
  assign redirect_valid = w_active;
  assign flush_ifid     = w_active;
  assign flush_idex     = w_active;
  assign squash_ex      = w_active;
  assign busy           = w_active;
  assign redirect_pc    = r_target;
  assign target_misalig = w_active && r_target[1];

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_br_inc),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_tk_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_tk_inc),
    .count (taken_count)
  );
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized self-checking bench for branch_redirect_unit against a
// transaction-level reference model.
module tb_branch_redirect_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  localparam logic [4:0] BR   = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] ALU  = 5'b01100;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [4:0]       ex_opcode;
  logic             ex_decision;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic             if_stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             target_misalig;
  logic             flush_ifid;
  logic             flush_idex;
  logic             squash_ex;
  logic             busy;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  int checks = 0;
  int errors = 0;
  int m_br   = 0;
  int m_tk   = 0;

  branch_redirect_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_decision    (ex_decision),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .if_stall       (if_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .target_misalig (target_misalig),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .squash_ex      (squash_ex),
    .busy           (busy),
    .br_count       (br_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle_inputs();
    ex_valid    = 1'b0;
    ex_opcode   = ALU;
    ex_decision = 1'b0;
    ex_pc       = '0;
    ex_imm      = '0;
    ex_rs1      = '0;
    if_stall    = 1'b0;
  endtask

  // One transfer presented in IDLE; if_stall held high for the first
  // n_stall redirect cycles. Wrong-path taken inputs are fed meanwhile.
  task automatic xfer(input logic v, input logic [4:0] op,
                      input logic dec, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs1,
                      input int n_stall, input string nm);
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [3:0]  flags;
    e_taken = v && ((op == BR && dec) || op == JAL || op == JALR);
    if (op == JALR) e_tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else            e_tgt = pc + imm;
    if (v && op == BR) begin
      m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (dec) m_tk = (m_tk < CMAX) ? m_tk + 1 : CMAX;
    end
    ex_valid = v; ex_opcode = op; ex_decision = dec;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; if_stall = 1'b0;
    step();
    if (e_taken) begin
      for (int c = 0; c <= n_stall; c++) begin
        flags = {redirect_valid, flush_ifid, flush_idex, squash_ex};
        checks++;
        if (flags !== 4'hF || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s flags cyc%0d got %b busy %b want 1111 busy 1",
                   nm, c, flags, busy);
        end
        checks++;
        if (redirect_pc !== e_tgt || target_misalig !== e_tgt[1]) begin
          errors++;
          $display("FAIL %s pc cyc%0d got %h mis %b want %h mis %b",
                   nm, c, redirect_pc, target_misalig, e_tgt, e_tgt[1]);
        end
        ex_valid    = 1'b1;
        ex_opcode   = ($urandom_range(0, 1) == 0) ? JAL : BR;
        ex_decision = 1'b1;
        ex_pc       = $urandom;
        ex_imm      = $urandom;
        if_stall    = (c < n_stall);
        step();
      end
    end
    flags = {redirect_valid, flush_ifid, flush_idex, squash_ex};
    checks++;
    if (flags !== 4'h0 || busy !== 1'b0 || target_misalig !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got flags %b busy %b mis %b want 0",
               nm, flags, busy, target_misalig);
    end
    checks++;
    if (br_count !== CNT_W'(m_br) || taken_count !== CNT_W'(m_tk)) begin
      errors++;
      $display("FAIL %s counts got %0d/%0d want %0d/%0d",
               nm, br_count, taken_count, m_br, m_tk);
    end
    drive_idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_opcode = JAL; ex_decision = $urandom;
      ex_pc = $urandom; ex_imm = $urandom; ex_rs1 = $urandom;
      if_stall = $urandom;
      step();
      checks++;
      if ({redirect_valid, flush_ifid, flush_idex, squash_ex, busy,
           target_misalig} !== 6'b0 || redirect_pc !== '0 ||
          br_count !== '0 || taken_count !== '0) begin
        errors++;
        $display("FAIL reset_hold got rv %b pc %h br %0d tk %0d want 0",
                 redirect_valid, redirect_pc, br_count, taken_count);
      end
    end
    drive_idle_inputs();
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy %b rv %b want 0 0",
               busy, redirect_valid);
    end
    m_br = 0; m_tk = 0;
  endtask

  task automatic test_beq_taken();
    xfer(1'b1, BR, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'h0, 0, "beq_taken");
    checks++;
    if (br_count !== 4'd1 || taken_count !== 4'd1) begin
      errors++;
      $display("FAIL beq_counts got %0d/%0d want 1/1", br_count, taken_count);
    end
  endtask

  task automatic test_jalr_and_not_taken();
    xfer(1'b1, JALR, 1'b0, 32'h40, 32'h4, 32'h2003, 0, "jalr_misalig");
    xfer(1'b1, BR, 1'b0, 32'h200, 32'h40, 32'h0, 0, "bne_not_taken");
    checks++;
    if (br_count !== 4'd2 || taken_count !== 4'd1) begin
      errors++;
      $display("FAIL bne_counts got %0d/%0d want 2/1", br_count, taken_count);
    end
    xfer(1'b1, ALU, 1'b1, 32'h300, 32'h8, 32'h0, 0, "non_transfer");
    xfer(1'b0, JAL, 1'b1, 32'h300, 32'h8, 32'h0, 0, "bubble_jal");
  endtask

  task automatic test_stall();
    xfer(1'b1, JAL, 1'b0, 32'h1000, 32'h80, 32'h0, 3, "jal_stall3");
    xfer(1'b1, BR, 1'b1, 32'h2000, 32'h10, 32'h0, 1, "beq_stall1");
  endtask

  task automatic test_wrap_saturate();
    xfer(1'b1, JAL, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, "pc_wrap");
    xfer(1'b1, JALR, 1'b0, 32'h0, 32'h7, 32'hFFFF_FFFF, 0, "jalr_wrap");
    for (int i = 0; i < 18; i++) begin
      xfer(1'b1, BR, i[0], 32'h500, 32'h20, 32'h0, 0, "sat_fill");
    end
    checks++;
    if (br_count !== 4'd15 || taken_count !== 4'd11) begin
      errors++;
      $display("FAIL saturate got %0d/%0d want 15/11", br_count, taken_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, JAL, 1'b0, 32'h100 * i, 32'h12, 32'h0, i % 2, "b2b");
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = BR;
        1:       op = JAL;
        2:       op = JALR;
        default: op = 5'($urandom);
      endcase
      xfer(1'($urandom_range(0, 4) != 0), op, 1'($urandom), $urandom,
           $urandom, $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_async_reset();
    ex_valid = 1'b1; ex_opcode = JAL; ex_pc = 32'h800; ex_imm = 32'h10;
    if_stall = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got busy %b rv %b want 1 1",
               busy, redirect_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({redirect_valid, flush_ifid, flush_idex, squash_ex, busy,
         target_misalig} !== 6'b0 || redirect_pc !== '0 ||
        br_count !== '0 || taken_count !== '0) begin
      errors++;
      $display("FAIL async_mid got rv %b busy %b pc %h br %0d want 0",
               redirect_valid, busy, redirect_pc, br_count);
    end
    m_br = 0; m_tk = 0;
    step();
    drive_idle_inputs();
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release got busy %b rv %b want 0 0",
               busy, redirect_valid);
    end
    xfer(1'b1, BR, 1'b1, 32'h40, 32'h40, 32'h0, 0, "post_reset");
  endtask

  initial begin
    drive_idle_inputs();
    rst = 1'b0;
    test_reset();
    test_beq_taken();
    test_jalr_and_not_taken();
    test_stall();
    test_wrap_saturate();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
